// File: rtl/decoder_seq.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with a valid/ready direct
// path and an autonomous scan mode that sweeps every code with a programmable dwell.
module decoder_seq #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        data_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   data_out,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        index,
    output logic                    wrap,
    output logic [1:0]              state_dbg
);

    localparam int OUT_W = 1 << SEL_W;
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};
    localparam logic [OUT_W-1:0] ONE      = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   data_nxt;
    logic               valid_nxt;
    logic [SEL_W-1:0]   index_nxt;
    logic               wrap_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               accept;

    function automatic logic [OUT_W-1:0] pattern(input logic [SEL_W-1:0] k);
        return INACTIVE ^ (ONE << k);
    endfunction

    // Handshake: a code is transferred on any rising edge where in_valid and
    // in_ready are both 1; in_ready depends only on enable/mode/rst, never on in_valid.
    assign in_ready  = enable & ~mode & ~rst;
    assign accept    = in_valid & in_ready;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        data_nxt  = data_out;
        valid_nxt = out_valid;
        index_nxt = index;
        wrap_nxt  = 1'b0;
        cnt_nxt   = cnt;

        if (!enable) begin
            state_nxt = IDLE;
        end else if (mode) begin
            state_nxt = SCAN;
        end else begin
            state_nxt = DIRECT;
        end

        case (state_nxt)
            DIRECT: begin
                cnt_nxt = '0;
                if (accept) begin
                    data_nxt  = pattern(data_in);
                    index_nxt = data_in;
                    valid_nxt = 1'b1;
                end else if (state != DIRECT) begin
                    // Leaving scan: nothing valid until the first accepted code.
                    data_nxt  = INACTIVE;
                    index_nxt = '0;
                    valid_nxt = 1'b0;
                end
            end
            SCAN: begin
                valid_nxt = 1'b1;
                if (state != SCAN) begin
                    data_nxt  = pattern('0);
                    index_nxt = '0;
                    cnt_nxt   = '0;
                end else if (cnt < dwell) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    // ">=" rather than "==" so a live dwell decrease below
                    // the current count steps on the very next edge.
                    cnt_nxt   = '0;
                    index_nxt = index + 1'b1;
                    data_nxt  = pattern(index + 1'b1);
                    wrap_nxt  = (index == {SEL_W{1'b1}});
                end
            end
            default: begin
                data_nxt  = INACTIVE;
                valid_nxt = 1'b0;
                index_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_out  <= INACTIVE;
            out_valid <= 1'b0;
            index     <= '0;
            wrap      <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            data_out  <= data_nxt;
            out_valid <= valid_nxt;
            index     <= index_nxt;
            wrap      <= wrap_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule
